zgated_photon_counter: RTL and testbench

Multi-channel successor to the single-channel SAPD pulse counter. It counts rising edges on CH asynchronous photon-pulse inputs into per-channel packed-BCD counters, with a per-channel dead-time holdoff after each accepted edge. In gated mode it accumulates over a programmable window and publishes a snapshot at the end of each window. In continuous mode it accumulates without clearing. It sits between the SAPD front-end/quench logic and the OLED/UART display controllers, which consume the packed BCD digits.

---
 rtl/zgated_photon_counter.sv | 160 ++++++++++++++++
 tb/tb_zgated_photon_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/zgated_photon_counter.sv
// Multi-channel photon edge counter with packed-BCD live counters, per-channel dead time,
// and gated (clear per window) or continuous accumulation, publishing a snapshot per window.
module zgated_photon_counter #(
  parameter int CH          = 4,
  parameter int DIGITS      = 8,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int GCW         = 26,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     clear,
  input  logic [CH-1:0]            pulse_in,
  output logic [CH*DIGITS*4-1:0]   bcd_q,
  output logic [CH-1:0]            overflow,
  output logic                     snap_valid,
  output logic                     gate_active
);

  localparam int W  = DIGITS * 4;
  localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_CYCLES);
  localparam logic [GCW-1:0] TERM      = GCW'(GATE_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] GATE = 2'd2;

  logic [1:0]             state;
  logic                   mode_l;
  logic [GCW-1:0]         gate_cnt;
  logic [CH-1:0]          sync1, sync2, sync3;
  logic [CH-1:0]          rise;
  logic [CH-1:0][W-1:0]   live, live_nxt;
  logic [CH-1:0][W:0]     inc;
  logic [CH-1:0]          ovf, ovf_nxt;
  logic [CH-1:0][DW-1:0]  dead, dead_nxt;
  logic                   counting;
  logic                   terminal;

  // Returns {saturated, value}; an all-9s input comes back unchanged with saturated set.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) return {1'b1, v};
    return {1'b0, r};
  endfunction

  assign rise        = sync2 & ~sync3;
  assign counting    = (state == GATE) && en;
  assign terminal    = counting && (gate_cnt == TERM);
  assign gate_active = (state == GATE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Dead timers run in every state; edges are only accepted while actively gating.
  always_comb begin
    live_nxt = live;
    ovf_nxt  = ovf;
    dead_nxt = dead;
    inc      = '0;
    for (int c = 0; c < CH; c++) begin
      inc[c] = bcd_inc(live[c]);
      if (dead[c] != '0) begin
        dead_nxt[c] = dead[c] - 1'b1;
      end else if (rise[c] && counting) begin
        dead_nxt[c] = DEAD_LOAD;
        live_nxt[c] = inc[c][W-1:0];
        ovf_nxt[c]  = ovf[c] | inc[c][W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_l     <= 1'b0;
      gate_cnt   <= '0;
      live       <= '0;
      ovf        <= '0;
      dead       <= '0;
      bcd_q      <= '0;
      overflow   <= '0;
      snap_valid <= 1'b0;
    end else if (clear) begin
      gate_cnt   <= '0;
      live       <= '0;
      ovf        <= '0;
      dead       <= '0;
      bcd_q      <= '0;
      overflow   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      dead       <= dead_nxt;
      case (state)
        IDLE: begin
          if (en) begin
            mode_l <= mode;
            state  <= ARM;
          end
        end
        ARM: begin
          live     <= '0;
          ovf      <= '0;
          dead     <= '0;
          gate_cnt <= '0;
          state    <= GATE;
        end
        GATE: begin
          if (!en) begin
            state <= IDLE;
          end else if (terminal) begin
            bcd_q      <= live_nxt;
            overflow   <= ovf_nxt;
            snap_valid <= 1'b1;
            gate_cnt   <= '0;
            if (mode_l) begin
              live <= live_nxt;
              ovf  <= ovf_nxt;
            end else begin
              live <= '0;
              ovf  <= '0;
            end
          end else begin
            live     <= live_nxt;
            ovf      <= ovf_nxt;
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zgated_photon_counter.sv
// Directed bench for zgated_photon_counter with an integer-count reference model checked every cycle.
module tb_zgated_photon_counter;
  localparam int CH = 4, DIGITS = 3, GATE = 100, GCW = 7, DEAD = 4;
  localparam int W = DIGITS * 4;
  localparam int MAXV = 999;

  logic clk = 1'b0;
  logic rst, en, mode, clear;
  logic [CH-1:0]   pulse_in;
  logic [CH*W-1:0] bcd_q;
  logic [CH-1:0]   overflow;
  logic            snap_valid, gate_active;

  zgated_photon_counter #(.CH(CH), .DIGITS(DIGITS), .GATE_CYCLES(GATE), .GCW(GCW), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .clear(clear), .pulse_in(pulse_in),
    .bcd_q(bcd_q), .overflow(overflow), .snap_valid(snap_valid), .gate_active(gate_active)
  );

  always #5 clk = ~clk;

  // Reference model: integer counts, last-accept timestamps, position within the window.
  int ecyc = 0;
  int cnt[CH], pub[CH], last[CH];
  bit [CH-1:0] movf, pubovf, h1, h2, h3;
  bit msnap, running, arming, mmode;
  int wpos;

  always @(posedge clk) begin
    ecyc++;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin cnt[c] = 0; pub[c] = 0; last[c] = -100; end
      movf = '0; pubovf = '0; h1 = '0; h2 = '0; h3 = '0;
      msnap = 0; running = 0; arming = 0; mmode = 0; wpos = 0;
    end else begin
      if (clear) begin
        for (int c = 0; c < CH; c++) begin cnt[c] = 0; pub[c] = 0; last[c] = -100; end
        movf = '0; pubovf = '0; msnap = 0; wpos = 0;
      end else if (!running && !arming) begin
        msnap = 0;
        if (en) begin arming = 1; mmode = mode; end
      end else if (arming) begin
        for (int c = 0; c < CH; c++) begin cnt[c] = 0; last[c] = -100; end
        movf = '0; msnap = 0; wpos = 0; arming = 0; running = 1;
      end else if (!en) begin
        running = 0; msnap = 0;
      end else begin
        // A pin sampled high two edges ago after being low three edges ago is a new edge now.
        for (int c = 0; c < CH; c++)
          if (h2[c] && !h3[c] && (ecyc - last[c] > DEAD)) begin
            last[c] = ecyc;
            if (cnt[c] == MAXV) movf[c] = 1'b1; else cnt[c]++;
          end
        if (wpos == GATE - 1) begin
          for (int c = 0; c < CH; c++) pub[c] = cnt[c];
          pubovf = movf; msnap = 1; wpos = 0;
          if (!mmode) begin
            for (int c = 0; c < CH; c++) cnt[c] = 0;
            movf = '0;
          end
        end else begin
          wpos++; msnap = 0;
        end
      end
      h3 = h2; h2 = h1; h1 = pulse_in;
    end
  end

  int tests = 0, fails = 0;

  function automatic logic [CH*W-1:0] exp_bcd();
    logic [CH*W-1:0] e;
    int v;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      v = pub[c];
      for (int d = 0; d < DIGITS; d++) begin
        e[c*W + d*4 +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return e;
  endfunction

  function automatic logic [W-1:0] dig(input int c);
    return bcd_q[c*W +: W];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, ecyc, act, exp);
    end
  endtask

  // Every cycle advance compares the DUT with the model, #1 after the active edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("model_bcd", 64'(bcd_q), 64'(exp_bcd()));
      chk("model_ovf", 64'(overflow), 64'(pubovf));
      chk("model_snap", 64'(snap_valid), 64'(msnap));
      chk("model_gate", 64'(gate_active), 64'(running));
    end
  endtask

  task automatic pulse(input logic [CH-1:0] m, input int gap);
    pulse_in = m;
    tick(1);
    pulse_in = '0;
    tick(gap - 1);
  endtask

  task automatic wait_snap(input int maxc);
    int n;
    n = 0;
    do begin tick(1); n++; end while (!snap_valid && n < maxc);
    if (!snap_valid) chk("snap_timeout", 64'(snap_valid), 64'd1);
  endtask

  int t0, saw;

  initial begin
    rst = 1; en = 0; mode = 0; clear = 0; pulse_in = '0;
    tick(1); pulse_in = '1; tick(1); pulse_in = '0;
    chk("rst_bcd", 64'(bcd_q), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_snap", 64'(snap_valid), 64'd0);
    chk("rst_gate", 64'(gate_active), 64'd0);
    rst = 0;
    tick(2);
    repeat (5) pulse(4'hF, 6);
    chk("idle_nocount", 64'(bcd_q), 64'd0);
    chk("idle_gate", 64'(gate_active), 64'd0);

    // Gated window with simultaneous edges on ch0 and ch2.
    mode = 0; en = 1; t0 = ecyc;
    tick(3);
    for (int i = 0; i < 12; i++) pulse((i < 7) ? 4'b0101 : 4'b0100, 6);
    wait_snap(200);
    chk("snap_latency", 64'(ecyc - t0), 64'd102);
    chk("win1_ch0", 64'(dig(0)), 64'h007);
    chk("win1_ch2", 64'(dig(2)), 64'h012);
    chk("win1_ch1", 64'(dig(1)), 64'h000);
    chk("win1_ch3", 64'(dig(3)), 64'h000);
    t0 = ecyc;
    wait_snap(200);
    chk("win2_period", 64'(ecyc - t0), 64'd100);
    chk("win2_zero", 64'(bcd_q), 64'd0);

    // Edge accepted on the terminal cycle (ch3) and on the first cycle of the next window (ch1).
    tick(97); pulse_in = 4'b1000; tick(1); pulse_in = 4'b0010; tick(1); pulse_in = '0;
    wait_snap(10);
    chk("term_ch3_in", 64'(dig(3)), 64'h001);
    chk("term_ch1_out", 64'(dig(1)), 64'h000);
    wait_snap(200);
    chk("next_ch1", 64'(dig(1)), 64'h001);
    chk("next_ch3", 64'(dig(3)), 64'h000);

    // Clear coincident with the terminal cycle.
    repeat (3) pulse(4'b0001, 6);
    tick(81); clear = 1; tick(1); clear = 0;
    chk("clr_term_snap", 64'(snap_valid), 64'd0);
    chk("clr_term_bcd", 64'(bcd_q), 64'd0);
    chk("clr_term_gate", 64'(gate_active), 64'd1);
    wait_snap(150);
    chk("clr_after_win", 64'(bcd_q), 64'd0);

    // Dead time: every 3 cycles only alternate edges count; every 5 cycles all count.
    repeat (10) pulse(4'b0010, 3);
    wait_snap(200);
    chk("dead_sp3", 64'(dig(1)), 64'h005);
    repeat (10) pulse(4'b0010, 5);
    wait_snap(200);
    chk("dead_sp5", 64'(dig(1)), 64'h010);

    // Abort mid-window: no snapshot, last snapshot held.
    pulse(4'b0001, 5); tick(20);
    en = 0; tick(1);
    chk("abort_gate", 64'(gate_active), 64'd0);
    saw = 0;
    for (int i = 0; i < 150; i++) begin tick(1); if (snap_valid) saw++; end
    chk("abort_nosnap", 64'(saw), 64'd0);
    chk("abort_hold1", 64'(dig(1)), 64'h010);
    chk("abort_hold0", 64'(dig(0)), 64'h000);

    // Mode change inside GATE must not take effect.
    mode = 0; en = 1; tick(3);
    chk("gate_on", 64'(gate_active), 64'd1);
    mode = 1;
    repeat (3) pulse(4'b0001, 6);
    wait_snap(200);
    chk("mode_w1", 64'(dig(0)), 64'h003);
    repeat (2) pulse(4'b0001, 6);
    wait_snap(200);
    chk("mode_w2", 64'(dig(0)), 64'h002);
    en = 0; tick(2);

    // Continuous mode: BCD carry, saturation and sticky overflow, then clear.
    mode = 1; en = 1; tick(3);
    repeat (100) pulse(4'b0100, 5);
    tick(3); wait_snap(200);
    chk("cont_100", 64'(dig(2)), 64'h100);
    repeat (899) pulse(4'b0100, 5);
    tick(3); wait_snap(200);
    chk("cont_999", 64'(dig(2)), 64'h999);
    chk("cont_999_ovf", 64'(overflow), 64'd0);
    pulse(4'b0100, 5);
    tick(3); wait_snap(200);
    chk("sat_bcd", 64'(dig(2)), 64'h999);
    chk("sat_ovf", 64'(overflow), 64'b0100);
    wait_snap(200);
    chk("sat_sticky", 64'(overflow), 64'b0100);
    clear = 1; tick(1); clear = 0;
    chk("clr_bcd", 64'(bcd_q), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    wait_snap(200);
    chk("clr_live", 64'(dig(2)), 64'h000);
    en = 0; tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
